// File: rtl/pzcorebus_pkg.sv
// Shared types for the pzcorebus request scheduler.
package pzcorebus_pkg;

    // Command arbiter states: IDLE picks a new winner, HOLD keeps the
    // latched winner until the downstream accepts its command.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pzcorebus_request_scheduler_state;

endpackage

// File: rtl/pzcorebus_request_scheduler_order_fifo.sv
// Small FIFO holding the master indices of accepted write commands, in
// acceptance order. The head is visible combinationally so that the data
// grant can follow it without an extra cycle.
module pzcorebus_request_scheduler_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        o_head = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Pointer registers; reset discards every queued entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/pzcorebus_request_scheduler.sv
// Round-robin command arbiter for N pzcorebus masters sharing one request
// channel. Write data follows command acceptance order through an order FIFO.
module pzcorebus_request_scheduler
    import pzcorebus_pkg::*;
#(
    parameter int N               = 2,
    parameter int DATA_FIFO_DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_mcmd_valid,
    input  logic [N-1:0] i_mcmd_with_data,
    output logic [N-1:0] o_scmd_accept,
    input  logic [N-1:0] i_mdata_valid,
    input  logic [N-1:0] i_mdata_last,
    output logic [N-1:0] o_sdata_accept,
    output logic [N-1:0] o_cmd_grant,
    output logic [N-1:0] o_data_grant,
    output logic         o_mcmd_valid,
    input  logic         i_scmd_accept,
    output logic         o_mdata_valid,
    input  logic         i_sdata_accept
);
    localparam int INDEX_WIDTH = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    pzcorebus_request_scheduler_state state_q;
    pzcorebus_request_scheduler_state state_d;
    logic [INDEX_WIDTH-1:0] rr_ptr_q;
    logic [INDEX_WIDTH-1:0] rr_ptr_d;
    logic [INDEX_WIDTH-1:0] winner_q;
    logic [INDEX_WIDTH-1:0] winner_d;

    logic [N-1:0]           eligible;
    logic                   pick_found;
    logic [INDEX_WIDTH-1:0] pick_idx;
    logic                   grant_valid;
    logic [INDEX_WIDTH-1:0] grant_idx;
    logic                   cmd_ack;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [INDEX_WIDTH-1:0] fifo_head;

    // Round-robin pick: scan from rr_ptr downward-priority so the closest
    // eligible master at or after rr_ptr wins. Writes are masked when the
    // order FIFO cannot take another entry.
    always_comb begin
        eligible   = i_mcmd_valid & ~(i_mcmd_with_data & {N{fifo_full}});
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (eligible[idx]) begin
                pick_found = 1'b1;
                pick_idx   = INDEX_WIDTH'(idx);
            end
        end
    end

    // Command FSM next state plus command-side outputs.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!i_rst) begin
            if (state_q == HOLD) begin
                grant_valid = 1'b1;
                grant_idx   = winner_q;
            end else begin
                grant_valid = pick_found;
                grant_idx   = pick_idx;
            end
        end
        o_cmd_grant   = grant_valid ? (ONE << grant_idx) : '0;
        o_mcmd_valid  = |(o_cmd_grant & i_mcmd_valid);
        o_scmd_accept = o_cmd_grant & {N{i_scmd_accept}};
        cmd_ack       = o_mcmd_valid && i_scmd_accept;
        fifo_push     = cmd_ack && i_mcmd_with_data[grant_idx];
        if (cmd_ack) begin
            rr_ptr_d = (grant_idx == INDEX_WIDTH'(N - 1)) ? '0
                                                          : grant_idx + INDEX_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (grant_valid && !i_scmd_accept) begin
                    state_d  = HOLD;
                    winner_d = grant_idx;
                end
            end
            HOLD: begin
                if (i_scmd_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data steering: only the master at the FIFO head may transfer data;
    // its last accepted beat retires the entry.
    always_comb begin
        o_data_grant   = (!i_rst && !fifo_empty) ? (ONE << fifo_head) : '0;
        o_mdata_valid  = |(o_data_grant & i_mdata_valid);
        o_sdata_accept = o_data_grant & {N{i_sdata_accept}};
        fifo_pop       = o_mdata_valid && i_sdata_accept && i_mdata_last[fifo_head];
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
        end
    end

    pzcorebus_request_scheduler_order_fifo #(
        .WIDTH (INDEX_WIDTH),
        .DEPTH (DATA_FIFO_DEPTH)
    ) u_order_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (fifo_push),
        .i_push_data (grant_idx),
        .i_pop       (fifo_pop),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_head      (fifo_head)
    );

endmodule

// File: tb/tb_pzcorebus_request_scheduler.sv
// Bench for the request scheduler: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_pzcorebus_request_scheduler;
    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] mcmd_valid;
    logic [N-1:0] mcmd_with_data;
    logic [N-1:0] scmd_accept_o;
    logic [N-1:0] mdata_valid;
    logic [N-1:0] mdata_last;
    logic [N-1:0] sdata_accept_o;
    logic [N-1:0] cmd_grant;
    logic [N-1:0] data_grant;
    logic         mcmd_valid_o;
    logic         scmd_accept_i;
    logic         mdata_valid_o;
    logic         sdata_accept_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_rr   = 0;
    int m_held = -1;
    int m_q[$];
    logic [N-1:0] m_cmd_acked;

    always #5 clk = ~clk;

    pzcorebus_request_scheduler #(.N(N), .DATA_FIFO_DEPTH(D)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_mcmd_valid     (mcmd_valid),
        .i_mcmd_with_data (mcmd_with_data),
        .o_scmd_accept    (scmd_accept_o),
        .i_mdata_valid    (mdata_valid),
        .i_mdata_last     (mdata_last),
        .o_sdata_accept   (sdata_accept_o),
        .o_cmd_grant      (cmd_grant),
        .o_data_grant     (data_grant),
        .o_mcmd_valid     (mcmd_valid_o),
        .i_scmd_accept    (scmd_accept_i),
        .o_mdata_valid    (mdata_valid_o),
        .i_sdata_accept   (sdata_accept_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Command winner for this cycle according to the arbitration rules.
    function automatic int model_pick();
        if (rst) return -1;
        if (m_held >= 0) return m_held;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (mcmd_valid[i] && !(mcmd_with_data[i] && m_q.size() >= D)) return i;
        end
        return -1;
    endfunction

    // One clock: check all outputs against the model, then advance the model.
    // want_cg / want_dg >= 0 add an explicit check of the grant vectors.
    task automatic step(input int want_cg, input int want_dg);
        int g;
        int h;
        logic [N-1:0] e_cg, e_dg, e_sa, e_da;
        logic e_mv, e_dv;
        #1;
        g    = model_pick();
        e_cg = (g >= 0) ? N'(1 << g) : '0;
        e_mv = |(e_cg & mcmd_valid);
        e_sa = scmd_accept_i ? e_cg : '0;
        h    = (!rst && m_q.size() > 0) ? m_q[0] : -1;
        e_dg = (h >= 0) ? N'(1 << h) : '0;
        e_dv = |(e_dg & mdata_valid);
        e_da = sdata_accept_i ? e_dg : '0;
        check("cmd_grant", 32'(cmd_grant), 32'(e_cg));
        check("mcmd_valid", 32'(mcmd_valid_o), 32'(e_mv));
        check("scmd_accept", 32'(scmd_accept_o), 32'(e_sa));
        check("data_grant", 32'(data_grant), 32'(e_dg));
        check("mdata_valid", 32'(mdata_valid_o), 32'(e_dv));
        check("sdata_accept", 32'(sdata_accept_o), 32'(e_da));
        if (want_cg >= 0) check("cmd_grant_exp", 32'(cmd_grant), 32'(want_cg));
        if (want_dg >= 0) check("data_grant_exp", 32'(data_grant), 32'(want_dg));
        m_cmd_acked = '0;
        @(posedge clk);
        if (rst) begin
            m_rr = 0;
            m_held = -1;
            m_q.delete();
        end else begin
            if (h >= 0 && mdata_valid[h] && sdata_accept_i) begin
                $display("data beat master %0d last %0b", h, mdata_last[h]);
                if (mdata_last[h]) void'(m_q.pop_front());
            end
            if (g >= 0) begin
                if (scmd_accept_i) begin
                    if (mcmd_valid[g]) begin
                        $display("cmd ack master %0d with_data %0b", g, mcmd_with_data[g]);
                        m_cmd_acked[g] = 1'b1;
                        m_rr = (g + 1) % N;
                        if (mcmd_with_data[g]) m_q.push_back(g);
                    end
                    m_held = -1;
                end else begin
                    m_held = g;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mcmd_valid = '0; mcmd_with_data = '0; mdata_valid = '0; mdata_last = '0;
        scmd_accept_i = 1'b0; sdata_accept_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
    endtask

    logic [N-1:0] pend_v;
    logic [N-1:0] pend_wd;

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();
        step(0, 0);

        // Reads from both masters: grants alternate.
        mcmd_valid = 2'b11; scmd_accept_i = 1'b1;
        step(1, 0); step(2, 0); step(1, 0); step(2, 0);

        // Master0 write held off by the downstream while master1 requests.
        do_reset();
        mcmd_valid = 2'b11; mcmd_with_data = 2'b01; scmd_accept_i = 1'b0;
        step(1, 0); step(1, 0);
        scmd_accept_i = 1'b1;
        step(1, 0);
        mcmd_valid = 2'b10; mcmd_with_data = 2'b00;
        step(2, 1);
        mcmd_valid = 2'b00; mdata_valid = 2'b01; sdata_accept_i = 1'b1;
        step(0, 1); step(0, 1);
        mdata_last = 2'b01;
        step(0, 1);
        idle_inputs();
        step(0, 0);

        // Master1 write then master0 write: data order follows acceptance.
        do_reset();
        mcmd_valid = 2'b10; mcmd_with_data = 2'b10; scmd_accept_i = 1'b1;
        step(2, 0);
        mcmd_valid = 2'b01; mcmd_with_data = 2'b01;
        step(1, 2);
        mcmd_valid = 2'b00; mdata_valid = 2'b11; sdata_accept_i = 1'b1;
        step(0, 2); step(0, 2);
        mdata_last = 2'b10;
        step(0, 2);
        mdata_last = 2'b01;
        step(0, 1);
        idle_inputs();
        step(0, 0);

        // Four writes fill the order FIFO; a fifth waits, a read passes.
        do_reset();
        mcmd_valid = 2'b01; mcmd_with_data = 2'b01; scmd_accept_i = 1'b1;
        repeat (4) step(1, -1);
        mcmd_valid = 2'b11;
        step(2, 1);
        mcmd_valid = 2'b01;
        step(0, 1);
        mdata_valid = 2'b01; mdata_last = 2'b01; sdata_accept_i = 1'b1;
        step(0, 1);
        mdata_valid = 2'b00;
        step(1, 1);
        mcmd_valid = 2'b00;
        repeat (4) step(0, 1);
        idle_inputs();
        do_reset();

        // Downstream data accept toggles during a 2-beat burst.
        mcmd_valid = 2'b01; mcmd_with_data = 2'b01; scmd_accept_i = 1'b1;
        step(1, 0);
        idle_inputs();
        mdata_valid = 2'b01; sdata_accept_i = 1'b1;
        step(0, 1);
        mdata_last = 2'b01; sdata_accept_i = 1'b0;
        step(0, 1);
        sdata_accept_i = 1'b1;
        step(0, 1);
        idle_inputs();
        step(0, 0);

        // Reset while holding a winner with two writes queued.
        mcmd_valid = 2'b01; mcmd_with_data = 2'b01; scmd_accept_i = 1'b1;
        step(1, 0); step(1, 1);
        mcmd_valid = 2'b10; mcmd_with_data = 2'b10; scmd_accept_i = 1'b0;
        step(2, 1);
        idle_inputs(); mcmd_valid = 2'b10; mcmd_with_data = 2'b10;
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0; idle_inputs();
        step(0, 0);
        mcmd_valid = 2'b11; scmd_accept_i = 1'b1;
        step(1, 0);
        idle_inputs();
        step(0, 0);

        // Random traffic; commands stay stable until accepted.
        pend_v = '0; pend_wd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 2) == 0)) begin
                    pend_v[i]  = 1'b1;
                    pend_wd[i] = 1'($urandom_range(0, 1));
                end
            end
            mcmd_valid     = pend_v;
            mcmd_with_data = pend_wd;
            scmd_accept_i  = ($urandom_range(0, 9) < 6);
            mdata_valid    = N'($urandom);
            mdata_last     = N'($urandom) & N'($urandom);
            sdata_accept_i = ($urandom_range(0, 9) < 7);
            rst            = ($urandom_range(0, 499) == 0);
            step(-1, -1);
            if (rst) pend_v = '0;
            pend_v = pend_v & ~m_cmd_acked;
        end
        rst = 1'b0;
        idle_inputs();
        step(-1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
